// File: rtl/pipeline_sink.sv
// Terminal consumer for the DIR/ack pipeline handshake: acknowledges each upstream word
// once and buffers it in a show-ahead FIFO drained by a local reader.
module pipeline_sink #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   DIR,
    input  logic [WIDTH-1:0]       data_in,
    output logic                   ack_prev,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_valid,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level,
    output logic [15:0]            word_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        WAIT_LOW
    } state_t;

    state_t state, next_state;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             accept;
    logic             pop;

    assign rd_valid = (level != '0);
    assign full     = (level == LW'(DEPTH));
    assign pop      = rd_en && rd_valid;
    assign rd_data  = mem[rd_ptr];

    // Acceptance only from IDLE and only on pre-edge occupancy, so a same-edge pop never frees a slot early.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (DIR && !full) begin
                    accept     = 1'b1;
                    next_state = ACK;
                end
            end
            ACK:      next_state = WAIT_LOW;
            WAIT_LOW: begin
                if (!DIR) begin
                    next_state = IDLE;
                end
            end
            default:  next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ack_prev   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            word_count <= '0;
        end else begin
            state    <= next_state;
            ack_prev <= accept;
            if (accept) begin
                wr_ptr     <= wr_ptr + AW'(1);
                word_count <= word_count + 16'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({accept, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= data_in;
        end
    end

endmodule

// File: tb/tb_pipeline_sink.sv
// Directed-vector bench for pipeline_sink: per-cycle table plus hand sequences
// for held DIR, pointer wrap and asynchronous reset.
module tb_pipeline_sink;

    logic        clk;
    logic        reset;
    logic        DIR;
    logic [7:0]  data_in;
    logic        ack_prev;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        full;
    logic [2:0]  level;
    logic [15:0] word_count;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic        dir;
        logic [7:0]  data;
        logic        rd;
        logic        ack;
        logic        val;
        logic [7:0]  head;
        logic [2:0]  lvl;
        logic        fl;
        logic [15:0] wc;
    } vec_t;

    vec_t vecs[$];

    pipeline_sink #(.DEPTH(4), .WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .DIR        (DIR),
        .data_in    (data_in),
        .ack_prev   (ack_prev),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .full       (full),
        .level      (level),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Inputs change 1ns after an edge; outputs are read 1ns after the following edge.
    task automatic apply_stimulus(input logic dir, input logic [7:0] data, input logic rd);
        DIR     = dir;
        data_in = data;
        rd_en   = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic av(input logic dir, input logic [7:0] data, input logic rd,
                      input logic ack, input logic val, input logic [7:0] head,
                      input logic [2:0] lvl, input logic fl, input logic [15:0] wc);
        vec_t v;
        v.dir = dir;  v.data = data; v.rd = rd;
        v.ack = ack;  v.val = val;   v.head = head;
        v.lvl = lvl;  v.fl = fl;     v.wc = wc;
        vecs.push_back(v);
    endtask

    initial begin
        int   ack_count;
        logic got_ack;

        tests_run    = 0;
        tests_failed = 0;
        reset   = 1'b0;
        DIR     = 1'b0;
        data_in = 8'h00;
        rd_en   = 1'b0;

        // Single transfer then pop
        av(1, 8'h2A, 0,  1, 1, 8'h2A, 1, 0, 1);
        av(1, 8'h2A, 0,  0, 1, 8'h2A, 1, 0, 1);
        av(0, 8'h00, 0,  0, 1, 8'h2A, 1, 0, 1);
        av(0, 8'h00, 1,  0, 0, 8'h00, 0, 0, 1);
        // Stream 01..04 into an empty FIFO without reading
        for (int k = 1; k <= 4; k++) begin
            av(1, 8'(k), 0, 1, 1, 8'h01, 3'(k), (k == 4), 16'(1 + k));
            av(1, 8'(k), 0, 0, 1, 8'h01, 3'(k), (k == 4), 16'(1 + k));
            av(0, 8'h00, 0, 0, 1, 8'h01, 3'(k), (k == 4), 16'(1 + k));
        end
        // Fifth word held off while full
        av(1, 8'h05, 0,  0, 1, 8'h01, 4, 1, 5);
        av(1, 8'h05, 0,  0, 1, 8'h01, 4, 1, 5);
        av(1, 8'h05, 0,  0, 1, 8'h01, 4, 1, 5);
        // Pop on the full edge does not accept; acceptance follows one edge later
        av(1, 8'h05, 1,  0, 1, 8'h02, 3, 0, 5);
        av(1, 8'h05, 0,  1, 1, 8'h02, 4, 1, 6);
        av(1, 8'h05, 0,  0, 1, 8'h02, 4, 1, 6);
        av(0, 8'h00, 0,  0, 1, 8'h02, 4, 1, 6);
        // Drain
        av(0, 8'h00, 1,  0, 1, 8'h03, 3, 0, 6);
        av(0, 8'h00, 1,  0, 1, 8'h04, 2, 0, 6);
        av(0, 8'h00, 1,  0, 1, 8'h05, 1, 0, 6);
        av(0, 8'h00, 1,  0, 0, 8'h00, 0, 0, 6);
        // Underflow attempts
        av(0, 8'h00, 1,  0, 0, 8'h00, 0, 0, 6);
        av(0, 8'h00, 1,  0, 0, 8'h00, 0, 0, 6);
        // Fill to two, then accept while popping
        av(1, 8'hA1, 0,  1, 1, 8'hA1, 1, 0, 7);
        av(1, 8'hA1, 0,  0, 1, 8'hA1, 1, 0, 7);
        av(0, 8'h00, 0,  0, 1, 8'hA1, 1, 0, 7);
        av(1, 8'hA2, 0,  1, 1, 8'hA1, 2, 0, 8);
        av(1, 8'hA2, 0,  0, 1, 8'hA1, 2, 0, 8);
        av(0, 8'h00, 0,  0, 1, 8'hA1, 2, 0, 8);
        av(1, 8'hA3, 1,  1, 1, 8'hA2, 2, 0, 9);
        av(1, 8'hA3, 0,  0, 1, 8'hA2, 2, 0, 9);
        av(0, 8'h00, 0,  0, 1, 8'hA2, 2, 0, 9);
        av(0, 8'h00, 1,  0, 1, 8'hA3, 1, 0, 9);
        av(0, 8'h00, 1,  0, 0, 8'h00, 0, 0, 9);

        #12;
        check_output("reset ack_prev", 32'(ack_prev), 32'd0);
        check_output("reset rd_valid", 32'(rd_valid), 32'd0);
        check_output("reset full", 32'(full), 32'd0);
        check_output("reset level", 32'(level), 32'd0);
        check_output("reset word_count", 32'(word_count), 32'd0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].dir, vecs[i].data, vecs[i].rd);
            check_output($sformatf("v%0d ack_prev", i), 32'(ack_prev), 32'(vecs[i].ack));
            check_output($sformatf("v%0d rd_valid", i), 32'(rd_valid), 32'(vecs[i].val));
            if (vecs[i].val)
                check_output($sformatf("v%0d rd_data", i), 32'(rd_data), 32'(vecs[i].head));
            check_output($sformatf("v%0d level", i), 32'(level), 32'(vecs[i].lvl));
            check_output($sformatf("v%0d full", i), 32'(full), 32'(vecs[i].fl));
            check_output($sformatf("v%0d word_count", i), 32'(word_count), 32'(vecs[i].wc));
        end

        // Held DIR: one acceptance per assertion
        ack_count = 0;
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b1, 8'h55, 1'b0);
            ack_count += int'(ack_prev);
        end
        check_output("held ack count", 32'(ack_count), 32'd1);
        check_output("held level", 32'(level), 32'd1);
        check_output("held word_count", 32'(word_count), 32'd10);
        apply_stimulus(1'b0, 8'h00, 1'b0);
        got_ack = 1'b0;
        for (int i = 0; i < 5 && !got_ack; i++) begin
            apply_stimulus(1'b1, 8'h56, 1'b0);
            got_ack = ack_prev;
        end
        check_output("reassert ack", 32'(got_ack), 32'd1);
        apply_stimulus(1'b1, 8'h56, 1'b0);
        apply_stimulus(1'b0, 8'h00, 1'b0);
        check_output("reassert level", 32'(level), 32'd2);
        check_output("reassert word_count", 32'(word_count), 32'd11);
        check_output("held head", 32'(rd_data), 32'h55);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        check_output("held second", 32'(rd_data), 32'h56);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        check_output("held drained", 32'(rd_valid), 32'd0);

        // Nine words through the FIFO so both pointers wrap repeatedly
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(1'b1, 8'hB0 + 8'(i), 1'b0);
            check_output($sformatf("wrap%0d ack", i), 32'(ack_prev), 32'd1);
            apply_stimulus(1'b1, 8'hB0 + 8'(i), 1'b0);
            apply_stimulus(1'b0, 8'h00, 1'b0);
            check_output($sformatf("wrap%0d data", i), 32'(rd_data), 32'(8'hB0 + 8'(i)));
            apply_stimulus(1'b0, 8'h00, 1'b1);
            check_output($sformatf("wrap%0d level", i), 32'(level), 32'd0);
        end
        check_output("wrap word_count", 32'(word_count), 32'd20);

        // Asynchronous reset in the middle of the ack cycle
        apply_stimulus(1'b1, 8'h33, 1'b0);
        check_output("pre-reset ack", 32'(ack_prev), 32'd1);
        #2;
        reset   = 1'b0;
        data_in = 8'h7F;
        #1;
        check_output("async ack_prev", 32'(ack_prev), 32'd0);
        check_output("async level", 32'(level), 32'd0);
        check_output("async word_count", 32'(word_count), 32'd0);
        check_output("async rd_valid", 32'(rd_valid), 32'd0);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_output("post-reset ack", 32'(ack_prev), 32'd1);
        check_output("post-reset word_count", 32'(word_count), 32'd1);
        check_output("post-reset level", 32'(level), 32'd1);
        check_output("post-reset rd_data", 32'(rd_data), 32'h7F);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipeline_sink.md
# pipeline_sink

Terminal consumer for the DIR/DOR + ack pipeline handshake. It sits after the last pipeline stage and accepts each word that stage presents. It returns the one-cycle ack pulse the stage waits for, and buffers accepted words in a small FIFO drained by a local reader. When the FIFO is full it withholds the ack, so backpressure propagates up the pipeline through the existing stage handshake.

## Interface
- `DEPTH`, default 4: FIFO entries; must be a power of two and ≥ 2.
- `WIDTH`, default 8: data word width.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low. Low clears all state immediately, independent of `clk`.
- `DIR`  in  1: upstream data-output-ready; level, held high by the upstream stage until it sees the ack.
- `data_in`  in  WIDTH: upstream data; valid while `DIR` is high.
- `ack_prev`  out  1: registered one-cycle accept pulse to the upstream stage's ack input.
- `rd_en`  in  1: reader pop request.
- `rd_data`  out  WIDTH: FIFO head (show-ahead); valid while `rd_valid` is high.
- `rd_valid`  out  1: FIFO not empty.
- `full`  out  1: level == DEPTH.
- `level`  out  log2(DEPTH)+1: current occupancy, 0..DEPTH.
- `word_count`  out  16: total words accepted since reset.

## Operation
- Reset values: `ack_prev`=0, `rd_valid`=0, `full`=0, `level`=0, `word_count`=0, state=IDLE, read/write pointers=0. `rd_data` is don't-care while empty.
- **IDLE**
  - If `DIR`=1 and `level`<DEPTH (sampled before the edge): write `data_in` at the write pointer, set `ack_prev`=1, increment `word_count`, go to ACK.
  - If `DIR`=1 and the FIFO is full: no write, no ack; stay in IDLE. This is backpressure.
- **ACK**
  - `ack_prev`←0 and go to WAIT_LOW, unconditionally.
  - `DIR` is still high here because upstream has not yet sampled the ack, so `DIR` is ignored in this state.
- **WAIT_LOW**
  - Stay while `DIR`=1; go to IDLE when `DIR`=0.
  - No capture happens in this state. This guarantees exactly one acceptance per upstream DOR assertion.
- **FIFO**
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - `level` is a separate counter: +1 on write only, −1 on pop only, unchanged on simultaneous write and pop.
- **Pop**
  - On `rd_en`=1 and `rd_valid`=1, advance the read pointer at the edge.
  - `rd_en` while empty is ignored; no underflow and no state change.
- **Full boundary**
  - The accept decision uses `level` before the edge.
  - A pop on the same edge as a full-state `DIR` does not enable acceptance on that edge; acceptance happens on the next edge.
- **Counter**: `word_count` wraps 16'hFFFF→0 with no flag.
- **Reset mid-transaction**
  - All outputs return to their reset values immediately; FIFO contents are discarded.
  - After reset release, a still-high `DIR` is treated as a new word in IDLE.

## Timing
- Accept: `DIR` sampled high at edge E0 in IDLE → `ack_prev` high from E0 to E1 (exactly one cycle). The word is visible on `rd_data`/`rd_valid` after E0 if the FIFO was empty.
- Upstream drops `DIR` at E1 (on seeing the ack). The sink is in WAIT_LOW after E1 and returns to IDLE at E2.
- Minimum spacing is one accepted word per 3 cycles, bounded by the upstream stage's own IDLE re-entry.
- Read latency: zero-cycle show-ahead. A pop at edge Ep presents the next entry after Ep.
- `full`, `rd_valid`, `level` are derived from registered occupancy and update on the same edge as the write or pop.

## Test plan
- **Single transfer**: after reset, DIR=1 with data_in=8'h2A until ack → `ack_prev` high exactly 1 cycle; then rd_valid=1, rd_data=8'h2A, level=1, word_count=1.
- **Stream and drain**: upstream sends 8'h01..8'h04 with DEPTH=4 and no reads → 4 acks, full=1, level=4. A fifth word 8'h05 with DIR held high gets no ack. Pop once → 8'h05 is acked on a following edge. Drain order is 01,02,03,04,05.
- **Held DIR**: DIR held high for 10 cycles with a constant word → exactly one ack and one FIFO write; a second ack occurs only after DIR falls and rises again.
- **Simultaneous write and pop**: level=2, accept a word on the same edge as rd_en=1 → level stays 2 and FIFO order is preserved.
- **Underflow and wrap**: rd_en pulses while empty → no change. Then push/pop 9 words through DEPTH=4 → pointers wrap and the data stays in order.
- **Async reset**: assert reset low mid-ACK, between clock edges → ack_prev, level, word_count, and rd_valid go to 0 immediately. After release with DIR high and data_in=8'h7F → accepted as word 1.
